// File: rtl/banked_mem_port.sv
// banked_mem_port
//   Single-port synchronous data memory with valid/ready request and response
//   handshakes, byte write enables, a READ_LAT-deep read pipeline, an
//   out-of-range error flag and a response buffer.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write                 1 = write, 0 = read
//   req_addr/req_wdata/req_be word address, write data, byte enables
//   rsp_valid/rsp_ready       read response handshake
//   rsp_rdata/rsp_err         read data, out-of-range flag
module banked_mem_port #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned RSP_DEPTH  = READ_LAT + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned WORDS = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

  // Storage and pipeline state
  logic [DATA_W-1:0]     r_mem [WORDS];
  logic                  r_pv  [READ_LAT];
  logic [DATA_W-1:0]     r_pd  [READ_LAT];
  logic                  r_pe  [READ_LAT];
  logic [DATA_W-1:0]     r_fd  [RSP_DEPTH];
  logic                  r_fe  [RSP_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_fcnt;
  logic [CNT_W-1:0]      r_outst;

  // Request-side decode
  logic                  w_accept;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [ADDR_W-1:0]     w_addr_hi;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;

  // Response-side control
  logic                  w_tail_v;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rsp_take;

  assign req_ready  = !rst && (r_outst < CNT_FULL);
  assign w_accept   = req_valid && req_ready;
  assign w_rd_acc   = w_accept && !req_write;
  assign w_wr_acc   = w_accept && req_write;
  assign w_addr_hi  = req_addr >> DEPTH_LOG2;
  assign w_in_range = (w_addr_hi == '0);
  assign w_idx      = req_addr[DEPTH_LOG2-1:0];

  // The last pipeline stage is visible directly when the buffer is empty, so a
  // read reaches the output READ_LAT cycles after accept. It is parked in the
  // buffer only when it cannot be handed over in the same cycle.
  assign w_tail_v     = r_pv[READ_LAT-1];
  assign w_fifo_empty = (r_fcnt == '0);
  assign w_push       = w_tail_v && !(w_fifo_empty && rsp_ready);
  assign w_pop        = !w_fifo_empty && rsp_ready;

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (!w_fifo_empty) begin
      rsp_valid = 1'b1;
      rsp_rdata = r_fd[r_rd_ptr];
      rsp_err   = r_fe[r_rd_ptr];
    end else if (w_tail_v) begin
      rsp_valid = 1'b1;
      rsp_rdata = r_pd[READ_LAT-1];
      rsp_err   = r_pe[READ_LAT-1];
    end
  end

  assign w_rsp_take = rsp_valid && rsp_ready;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline; stage 0 samples the array contents from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < READ_LAT; s++) begin
        r_pv[s] <= 1'b0;
        r_pd[s] <= '0;
        r_pe[s] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_rd_acc;
      r_pd[0] <= (w_rd_acc && w_in_range) ? r_mem[w_idx] : '0;
      r_pe[0] <= w_rd_acc && !w_in_range;
      for (int unsigned s = 1; s < READ_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pd[s] <= r_pd[s-1];
        r_pe[s] <= r_pe[s-1];
      end
    end
  end

  // Response buffer. Admission is bounded by r_outst, so it cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < RSP_DEPTH; e++) begin
        r_fd[e] <= '0;
        r_fe[e] <= 1'b0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fcnt   <= '0;
    end else begin
      if (w_push) begin
        r_fd[r_wr_ptr] <= r_pd[READ_LAT-1];
        r_fe[r_wr_ptr] <= r_pe[READ_LAT-1];
        r_wr_ptr       <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Reads accepted but not yet taken on the response side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outst <= '0;
    end else begin
      case ({w_rd_acc, w_rsp_take})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

endmodule
